mem_bus_unit: RTL
=================

// Module: mem_bus_unit
// PURPOSE
// Memory access unit between the CPU control unit/datapath and the external memory bus.
// Registers each CPU memory request (fetch, operand read or write) and drives a valid/ready bus handshake.
// Stalls the controller FSM until the access completes, then presents read data for one cycle.
// Bounds every access with a wait-state timeout.
// PARAMETERS
// ADDR_W   16   address width
// DATA_W   16   data width
// TIMEOUT  255  max BUSY cycles without bus_ready before abort; 1..255, counter is 8 bits
// PORTS
// clk        in   1       clock, rising edge
// rst        in   1       reset, asynchronous, active-low (0 = reset)
// cpu_req    in   1       access request; = saveOpcode | saveMem | we from controller
// cpu_we     in   1       1 = write, 0 = read
// cpu_addr   in   ADDR_W  resolved memory address (memAddr mux output)
// cpu_wdata  in   DATA_W  write data (writeDataSource mux output)
// cpu_rdata  out  DATA_W  read data to instruction/value registers
// cpu_stall  out  1       1 = freeze controller state and all register enables this cycle
// bus_valid  out  1       bus request valid
// bus_we     out  1       bus write strobe, qualified by bus_valid
// bus_addr   out  ADDR_W  bus address
// bus_wdata  out  DATA_W  bus write data
// bus_ready  in   1       memory accepts (write) / returns data (read)
// bus_rdata  in   DATA_W  memory read data, sampled when bus_valid & bus_ready
// err_clr    in   1       clears bus_err
// bus_err    out  1       sticky timeout flag
// BEHAVIOUR
// - Reset (rst=0, immediate): state=IDLE; bus_valid, bus_we, bus_err = 0; bus_addr, bus_wdata,
//   cpu_rdata (rdata_q) = 0; wait counter = 0.
// - States:
//   - IDLE: if cpu_req, capture cpu_addr/cpu_wdata/cpu_we into bus regs, clear counter, go to BUSY.
//   - BUSY: bus_valid=1 with the captured values.
//     - bus_ready=1: reads latch bus_rdata into rdata_q; go to DONE.
//     - else counter+1; when counter==TIMEOUT-1 with no ready: rdata_q=all ones, bus_err<=1, go to DONE.
//   - DONE: bus_valid=0; always go to IDLE. The controller advances on this edge.
// - cpu_stall = cpu_req & (state != DONE). Combinational from state and cpu_req.
// - Minimum access: request in cycle 0 (IDLE), BUSY in cycle 1 with ready, DONE in cycle 2.
//   Stall is high in cycles 0-1.
// - Each extra BUSY cycle without ready adds one stall cycle.
// - Writes leave rdata_q unchanged. cpu_rdata = rdata_q, which holds until the next completed read.
// - bus_addr, bus_wdata and bus_we are stable for the whole BUSY phase.
//   cpu_addr/cpu_wdata changes during BUSY/DONE are ignored.
// - Ready arriving in the timeout cycle counts as success: no error, real data.
// - bus_ready while not BUSY: ignored.
// - cpu_req in DONE does not start a new access. The next access starts from IDLE the following cycle.
// - bus_err: set on timeout, cleared by err_clr. Set wins if both happen in the same cycle.
// - Reset mid-BUSY: bus_valid drops asynchronously and the access is lost (no completion).
// TESTING
// 1. Read, zero wait: req, addr=0x0010, we=0; ready in first BUSY, rdata=0xBEEF
//    -> stall 2 cycles; DONE cycle cpu_rdata=0xBEEF, stall=0.
// 2. Write, 3 wait: addr=0x0200, wdata=0x1234; ready on 4th BUSY cycle
//    -> bus_valid/bus_we high 4 cycles, addr/data stable, rdata_q unchanged.
// 3. Timeout, TIMEOUT=8, ready never -> bus_valid high exactly 8 cycles; cpu_rdata=0xFFFF;
//    bus_err=1 until err_clr pulse, then 0; err_clr+timeout same cycle -> stays 1.
// 4. cpu_addr 0x0010->0x0055 mid-BUSY -> bus_addr stays 0x0010; ready with stray bus_ready in IDLE -> no access.
// 5. rst=0 during BUSY (2nd wait cycle) -> bus_valid=0 same cycle, all outputs 0, state IDLE after release.
// 6. Back-to-back fetch then operand read (FETCH->RIMMED): 2nd BUSY starts 2 cycles after 1st DONE
//    with the new address; rdata follows each access.

Source files
------------

// File: rtl/mem_bus_unit.sv
// Memory access unit: registers one CPU request, runs a valid/ready bus handshake,
// stalls the controller until completion and bounds each access with a wait-state timeout.
module mem_bus_unit #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   output logic              bus_valid,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              err_clr,
   output logic              bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic [7:0]        r_wait;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;
   logic              r_err;
   logic              w_hit;
   logic              w_timeout;

   // Ready is checked before the timeout so a reply in the last allowed cycle still succeeds.
   assign w_hit     = (r_state == S_BUSY) && bus_ready;
   assign w_timeout = (r_state == S_BUSY) && !bus_ready && (r_wait == 8'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves w_next unassigned (no latch).
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (cpu_req) w_next = S_BUSY;
         S_BUSY:  if (w_hit || w_timeout) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // bus_valid follows the state register directly, so reset drops it without waiting for a clock.
   always_comb begin
      bus_valid = (r_state == S_BUSY);
      bus_we    = r_we && (r_state == S_BUSY);
      cpu_stall = cpu_req && (r_state != S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait  <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  r_we    <= cpu_we;
                  r_addr  <= cpu_addr;
                  r_wdata <= cpu_wdata;
                  r_wait  <= '0;
               end
            end
            S_BUSY: begin
               if (bus_ready) begin
                  if (!r_we) r_rdata <= bus_rdata;
               end else if (w_timeout) begin
                  r_rdata <= '1;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Sticky error: a timeout in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      else if (err_clr)   r_err <= 1'b0;
   end

   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign cpu_rdata = r_rdata;
   assign bus_err   = r_err;

endmodule
